// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit. It issues up to inst_num instructions from an
// asynchronous-read instruction memory into a registered instn/instn_valid
// pair for the controller. It inserts one bubble for a not-taken BEQ and two
// bubbles for a taken BEQ.
//
// Handshake: there is no ready signal. instn_valid=1 marks instn as a real
// fetched word for exactly one cycle per non-stalled edge. instn_valid=0
// marks a bubble (instn=NOP_INSTN). stall=1 is the only backpressure, and it
// freezes every register unless the FSM is in IDLE.
module instr_fetch_unit #(
  parameter int                PC_W      = 32,
  parameter logic [PC_W-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTN = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       inst_num,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              beq_enable,
  input  logic              PCSrc,
  input  logic [PC_W-1:0]   branch_target,
  output logic [31:0]       instn,
  output logic              instn_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_BR_WAIT  = 2'd2,
    S_BR_FLUSH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       instn_q, instn_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic              count_nz;
  logic              do_fetch;
  logic              do_bubble;

  assign count_nz = (count_q != 16'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a stall holds the state everywhere except IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (inst_num != 16'd0)) state_d = S_RUN;
      end
      S_RUN: begin
        if (!stall) begin
          if (beq_enable)     state_d = S_BR_WAIT;
          else if (!count_nz) state_d = S_IDLE;
        end
      end
      S_BR_WAIT: begin
        if (!stall) begin
          if (PCSrc)          state_d = S_BR_FLUSH;
          else if (count_nz)  state_d = S_RUN;
          else                state_d = S_IDLE;
        end
      end
      S_BR_FLUSH: begin
        if (!stall) state_d = count_nz ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: choose fetch, bubble or done for this edge
  always_comb begin
    pc_d      = pc_q;
    count_d   = count_q;
    instn_d   = instn_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    do_fetch  = 1'b0;
    do_bubble = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instn_d = NOP_INSTN;
        valid_d = 1'b0;
        if (start) begin
          if (inst_num != 16'd0) begin
            pc_d    = RESET_PC;
            count_d = inst_num;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!stall) begin
          // A BEQ sitting in instn wins over the next fetch
          if (beq_enable) begin
            do_bubble = 1'b1;
          end else if (count_nz) begin
            do_fetch = 1'b1;
          end else begin
            do_bubble = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      S_BR_WAIT: begin
        if (!stall) begin
          if (PCSrc) begin
            do_bubble = 1'b1;
            pc_d      = branch_target;
          end else if (count_nz) begin
            do_fetch = 1'b1;
          end else begin
            do_bubble = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      S_BR_FLUSH: begin
        if (!stall) begin
          if (count_nz) begin
            do_fetch = 1'b1;
          end else begin
            do_bubble = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      default: begin
        instn_d = NOP_INSTN;
        valid_d = 1'b0;
      end
    endcase

    if (do_fetch) begin
      instn_d = imem_rdata;
      valid_d = 1'b1;
      pc_d    = pc_q + PC_W'(4);
      count_d = count_q - 16'd1;
    end
    if (do_bubble) begin
      instn_d = NOP_INSTN;
      valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      count_q <= 16'd0;
      instn_q <= NOP_INSTN;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      instn_q <= instn_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instn       = instn_q;
  assign instn_valid = valid_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a small controller emulation drives beq_enable,
// PCSrc and branch_target, and a program-level reference model predicts every
// observed cycle.
module tb_instr_fetch_unit;

  localparam int          PC_W   = 32;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          OBS_W  = 3 + PC_W + 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [15:0]       inst_num;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              beq_enable;
  logic              PCSrc;
  logic [PC_W-1:0]   branch_target;
  logic [31:0]       instn;
  logic              instn_valid;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;

  logic [31:0]       mem [0:255];
  logic [PC_W-1:0]   model_pc;
  logic [OBS_W-1:0]  exp_q[$];
  int                checks;
  int                failures;

  assign imem_rdata = mem[imem_addr[9:2]];

  instr_fetch_unit #(
    .PC_W      (PC_W),
    .RESET_PC  (RST_PC),
    .NOP_INSTN (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .inst_num      (inst_num),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .beq_enable    (beq_enable),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .instn         (instn),
    .instn_valid   (instn_valid),
    .busy          (busy),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Program encoding used by the emulated controller:
  // opcode 7'h63 = BEQ, bit31 = taken, bits[29:22] = target word index.
  function automatic logic is_beq(input logic [31:0] w);
    return w[6:0] == 7'h63;
  endfunction

  function automatic logic [PC_W-1:0] target_of(input logic [31:0] w);
    return {22'd0, w[29:22], 2'b00};
  endfunction

  function automatic logic [31:0] plain_word();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = 7'h13;
    return w;
  endfunction

  function automatic logic [31:0] beq_word(input logic taken, input logic [7:0] tgt);
    logic [31:0] w;
    w = $urandom;
    w[31] = taken;
    w[29:22] = tgt;
    w[6:0] = 7'h63;
    return w;
  endfunction

  function automatic logic [OBS_W-1:0] pack(input logic b, input logic d, input logic v,
                                            input logic [PC_W-1:0] a, input logic [31:0] i);
    return {b, d, v, a, i};
  endfunction

  function automatic logic [OBS_W-1:0] observed();
    return {busy, done, instn_valid, imem_addr, instn};
  endfunction

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) mem[i] = plain_word();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(3) == 0) mem[i] = beq_word(1'($urandom_range(1)), 8'($urandom_range(255)));
      else                        mem[i] = plain_word();
    end
  endtask

  // Controller emulation: raise beq_enable while a valid BEQ sits in instn
  task automatic drive_controller();
    beq_enable = instn_valid && is_beq(instn);
    if (beq_enable) begin
      PCSrc         = instn[31];
      branch_target = target_of(instn);
    end
  endtask

  // Reference model: expected per-cycle observations for one program run
  task automatic build_expected(input int n);
    logic [PC_W-1:0] pc;
    logic [31:0]     w;
    exp_q.delete();
    if (n == 0) begin
      pc = model_pc;
    end else begin
      pc = RST_PC;
      exp_q.push_back(pack(1'b1, 1'b0, 1'b0, pc, NOP));
      for (int k = 0; k < n; k++) begin
        w  = mem[pc[9:2]];
        pc = pc + 32'd4;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b1, pc, w));
        if (is_beq(w)) begin
          exp_q.push_back(pack(1'b1, 1'b0, 1'b0, pc, NOP));
          if (w[31]) begin
            pc = target_of(w);
            exp_q.push_back(pack(1'b1, 1'b0, 1'b0, pc, NOP));
          end
        end
      end
    end
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, pc, NOP));
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, pc, NOP));
    model_pc = pc;
  endtask

  // Runs one program and compares every cycle against the model
  task automatic run_program(input string name, input int n, input int stall_pct,
                             input int stall_at, input int stall_len, input bit start_noise);
    logic [OBS_W-1:0] prev;
    logic             can_hold;
    int               cyc;
    build_expected(n);
    @(negedge clk);
    start = 1'b1; inst_num = 16'(n); stall = 1'b0; beq_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; inst_num = 16'($urandom);
    prev = exp_q.pop_front();
    checks++;
    if (observed() !== prev) begin
      failures++;
      $display("FAIL %s start cyc=0 got=%h exp=%h", name, observed(), prev);
    end
    cyc = 1;
    while (exp_q.size() > 0) begin
      drive_controller();
      can_hold = (n > 0) && (exp_q.size() > 1);
      stall = can_hold && (((stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len))
                           || (int'($urandom_range(99)) < stall_pct));
      start = start_noise && can_hold && ($urandom_range(3) == 0);
      inst_num = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (!stall) prev = exp_q.pop_front();
      checks++;
      if (observed() !== prev) begin
        failures++;
        $display("FAIL %s cyc=%0d stall=%0b got=%h exp=%h", name, cyc, stall, observed(), prev);
      end
      cyc++;
    end
    stall = 1'b0; start = 1'b0; beq_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; inst_num = 16'd0; stall = 1'b0;
    beq_enable = 1'b0; PCSrc = 1'b0; branch_target = '0;
    fill_plain();
    #12;
    checks++;
    if (observed() !== pack(1'b0, 1'b0, 1'b0, RST_PC, NOP)) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", observed(), pack(1'b0, 1'b0, 1'b0, RST_PC, NOP));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (observed() !== pack(1'b0, 1'b0, 1'b0, RST_PC, NOP)) begin
      failures++;
      $display("FAIL reset_no_fetch got=%h exp=%h", observed(), pack(1'b0, 1'b0, 1'b0, RST_PC, NOP));
    end
    model_pc = RST_PC;
  endtask

  task automatic test_basic();
    fill_plain();
    run_program("basic_abc", 3, 0, -1, 0, 1'b0);
  endtask

  task automatic test_beq_not_taken();
    fill_plain();
    mem[1] = beq_word(1'b0, 8'h10);
    run_program("beq_not_taken", 4, 0, -1, 0, 1'b0);
  endtask

  task automatic test_beq_taken();
    fill_plain();
    mem[1] = beq_word(1'b1, 8'h10);
    run_program("beq_taken", 4, 0, -1, 0, 1'b0);
  endtask

  task automatic test_stall();
    fill_plain();
    run_program("stall_2cyc", 5, 0, 2, 2, 1'b0);
  endtask

  task automatic test_boundaries();
    fill_plain();
    run_program("zero_count", 0, 0, -1, 0, 1'b0);
    mem[1] = beq_word(1'b1, 8'h20);
    run_program("final_beq_taken", 2, 0, -1, 0, 1'b0);
    mem[1] = beq_word(1'b0, 8'h20);
    run_program("final_beq_not_taken", 2, 0, -1, 0, 1'b0);
    run_program("start_while_busy", 6, 0, -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_branch();
    fill_plain();
    mem[1] = beq_word(1'b1, 8'h10);
    @(negedge clk);
    start = 1'b1; inst_num = 16'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_controller();
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (observed() !== pack(1'b1, 1'b0, 1'b0, 32'd8, NOP)) begin
      failures++;
      $display("FAIL mid_branch_setup got=%h exp=%h", observed(), pack(1'b1, 1'b0, 1'b0, 32'd8, NOP));
    end
    drive_controller();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== pack(1'b0, 1'b0, 1'b0, RST_PC, NOP)) begin
      failures++;
      $display("FAIL mid_branch_reset got=%h exp=%h", observed(), pack(1'b0, 1'b0, 1'b0, RST_PC, NOP));
    end
    beq_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = RST_PC;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (observed() !== pack(1'b0, 1'b0, 1'b0, RST_PC, NOP)) begin
      failures++;
      $display("FAIL mid_branch_idle got=%h exp=%h", observed(), pack(1'b0, 1'b0, 1'b0, RST_PC, NOP));
    end
    run_program("after_reset", 3, 0, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      fill_random();
      run_program($sformatf("random_%0d", t),
                  ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1)),
                  25, -1, 0, 1'b1);
    end
  endtask

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_beq_not_taken();
    test_beq_taken();
    test_stall();
    test_boundaries();
    test_reset_mid_branch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter PC_W, default 32, PC and address width (byte-addressed).
REQ-002 Parameter RESET_PC, default 0, PC loaded by reset and by start.
REQ-003 Parameter NOP_INSTN, default 32'h0000_0000, bubble word (decodes to default/no-write in controller).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse; begins fetching at RESET_PC.
REQ-007 inst_num  in  16  instructions to issue, sampled on start; 0 means none.
REQ-008 imem_addr  out  PC_W  instruction memory address, equals PC register.
REQ-009 imem_rdata  in  32  instruction word at imem_addr, same-cycle (asynchronous read).
REQ-010 stall  in  1  hold: freeze PC, instn, counter, state.
REQ-011 beq_enable  in  1  from controller; high with a BEQ in decode.
REQ-012 PCSrc  in  1  branch-taken flag, valid in BR_WAIT.
REQ-013 branch_target  in  PC_W  taken-branch address, valid with PCSrc.
REQ-014 instn  out  32  registered instruction to controller.
REQ-015 instn_valid  out  1  instn is a real fetched instruction (0 for bubbles).
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse when the last instruction has been issued.

Function
REQ-018 FSM states: IDLE, RUN, BR_WAIT, BR_FLUSH; reset state IDLE.
REQ-019 IDLE: instn=NOP_INSTN, instn_valid=0; start with inst_num>0 -> RUN, PC<=RESET_PC, count<=inst_num; start with inst_num=0 -> done pulse, stay IDLE.
REQ-020 RUN, no stall, no beq_enable: instn<=imem_rdata, instn_valid<=1, PC<=PC+4 (mod 2^PC_W), count<=count-1.
REQ-021 RUN with beq_enable=1 (BEQ currently in instn): issue bubble (instn<=NOP_INSTN, valid<=0), PC held, -> BR_WAIT; beq_enable has priority over fetch.
REQ-022 BR_WAIT, PCSrc=0: fetch as REQ-020, -> RUN (one bubble total).
REQ-023 BR_WAIT, PCSrc=1: PC<=branch_target, bubble, -> BR_FLUSH.
REQ-024 BR_FLUSH: fetch from branch_target as REQ-020, -> RUN (two bubbles total, matching controller EQUAL state).
REQ-025 Fetch in RUN/BR_WAIT/BR_FLUSH occurs only while count>0; issuing the fetch that makes count 0 asserts done the following cycle and returns to IDLE unless that instruction is a BEQ.
REQ-026 A final BEQ completes its BR_WAIT (and BR_FLUSH if taken) with bubbles only, then done pulse, -> IDLE.
REQ-027 stall=1 freezes all registers in every state except IDLE; beq_enable/PCSrc are not sampled while stalled.
REQ-028 start ignored while busy=1.
REQ-029 Bubbles never decrement count.

Reset
REQ-030 rst_n low, any time including mid-branch: state=IDLE, PC=RESET_PC, count=0, instn=NOP_INSTN, instn_valid=0, done=0, busy=0, immediately (asynchronous).
REQ-031 First rising edge after rst_n release performs no fetch unless start is high.

Verification
REQ-032 start, inst_num=3, memory of non-branch words A,B,C -> instn A,B,C on consecutive cycles, valid=1, imem_addr 0,4,8, done one cycle after C.
REQ-033 BEQ at address 4, PCSrc=0 -> sequence BEQ, bubble, word@8; count unchanged by bubble.
REQ-034 BEQ at address 4, PCSrc=1, branch_target=0x40 -> BEQ, bubble, bubble, word@0x40, then word@0x44.
REQ-035 stall high 2 cycles during RUN -> instn/imem_addr held 2 cycles, sequence resumes unchanged.
REQ-036 rst_n low during BR_WAIT -> outputs at reset values same cycle; next start fetches from RESET_PC.
REQ-037 start with inst_num=0 -> done pulse next cycle, instn_valid never 1; last instruction BEQ taken -> two bubbles then done.
